multi_cycle_control_112: RTL and testbench

- Moore FSM controller that sequences a shared-resource multi-cycle MIPS datapath: one ALU, one unified instruction/data memory, and an instruction register (IR).
- Decodes op/func from the IR and steps each instruction through IF, ID, EX, MEM and WB states.
- Drives every datapath enable and mux select.
- Keeps a retired-instruction counter for bring-up and verification.

---
 rtl/ctrl_pkg_112.sv | 82 ++++++++
 rtl/alu_dec_112.sv | 23 ++
 rtl/multi_cycle_control_112.sv | 183 ++++++++++++++++++
 tb/tb_multi_cycle_control_112.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg_112.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, funcs and select codes.
// The HALT state exists only when ILLEGAL_TRAP_EN is defined.
package ctrl_pkg_112;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNC_W   = 6;
  localparam int unsigned ALUCTR_W = 3;
  localparam int unsigned SRCB_W   = 2;
  localparam int unsigned PCSRC_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EX_R = 4'd2,
    S_WB_R = 4'd3,
    S_EX_I = 4'd4,
    S_WB_I = 4'd5,
    S_MA   = 4'd6,
    S_MRD  = 4'd7,
    S_MWB  = 4'd8,
    S_MWR  = 4'd9,
    S_BR   = 4'd10,
    S_JMP  = 4'd11
`ifdef ILLEGAL_TRAP_EN
    , S_HALT = 4'd12
`endif
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [FUNC_W-1:0] FUNC_ADDU = 6'b100001;
  localparam logic [FUNC_W-1:0] FUNC_SUBU = 6'b100011;
  localparam logic [FUNC_W-1:0] FUNC_AND  = 6'b100100;
  localparam logic [FUNC_W-1:0] FUNC_OR   = 6'b100101;
  localparam logic [FUNC_W-1:0] FUNC_SLT  = 6'b101010;

  localparam logic [ALUCTR_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTR_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUCTR_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUCTR_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUCTR_W-1:0] ALU_SLT = 3'b100;

  localparam logic [SRCB_W-1:0] SRCB_REG    = 2'b00;
  localparam logic [SRCB_W-1:0] SRCB_FOUR   = 2'b01;
  localparam logic [SRCB_W-1:0] SRCB_IMM    = 2'b10;
  localparam logic [SRCB_W-1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [PCSRC_W-1:0] PCSRC_ALU    = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JUMP   = 2'b10;

  // Complete datapath control word driven each cycle.
  typedef struct packed {
    logic                pc_wr;
    logic                pc_wr_cond;
    logic                iord;
    logic                mem_wr;
    logic                ir_wr;
    logic                reg_dst;
    logic                reg_wr;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic [SRCB_W-1:0]   alu_src_b;
    logic [ALUCTR_W-1:0] alu_ctr;
    logic [PCSRC_W-1:0]  pc_src;
    logic                ext_op;
  } ctrl_t;

  // States whose exit retires an instruction.
  function automatic logic is_terminal(input state_t s);
    return (s == S_WB_R) || (s == S_WB_I) || (s == S_MWB) ||
           (s == S_MWR)  || (s == S_BR)   || (s == S_JMP);
  endfunction

endpackage

// File: rtl/alu_dec_112.sv
// R-type func decoder: maps func to an ALU operation and flags funcs the datapath does not support.
module alu_dec_112
  import ctrl_pkg_112::*;
(
  input  logic [FUNC_W-1:0]   func,
  output logic [ALUCTR_W-1:0] alu_ctr_c,
  output logic                illegal_c
);

  always_comb begin
    alu_ctr_c = ALU_ADD;
    illegal_c = 1'b0;
    case (func)
      FUNC_ADDU: alu_ctr_c = ALU_ADD;
      FUNC_SUBU: alu_ctr_c = ALU_SUB;
      FUNC_AND:  alu_ctr_c = ALU_AND;
      FUNC_OR:   alu_ctr_c = ALU_OR;
      FUNC_SLT:  alu_ctr_c = ALU_SLT;
      default:   illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control_112.sv
// Moore controller for a shared-ALU, unified-memory multi-cycle MIPS datapath, with a retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap unknown op/func into a sticky HALT state instead of treating them as NOPs.
module multi_cycle_control_112
  import ctrl_pkg_112::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_W-1:0]     op,
  input  logic [FUNC_W-1:0]   func,
  input  logic                Zero,
  output logic                PCWr,
  output logic                PCWrCond,
  output logic                IorD,
  output logic                MemWr,
  output logic                IRWr,
  output logic                RegDst,
  output logic                RegWr,
  output logic                MemtoReg,
  output logic                ALUsrcA,
  output logic [SRCB_W-1:0]   ALUsrcB,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [PCSRC_W-1:0]  PCsrc,
  output logic                ExtOp,
  output logic [STATE_W-1:0]  state,
  output logic [CNT_W-1:0]    instr_cnt
);

  state_t              cur_state;
  state_t              next_state;
  ctrl_t               ctrl;
  logic [ALUCTR_W-1:0] dec_ctr;
  logic                dec_illegal;

  // Zero only qualifies PCWrCond inside the datapath; the controller never needs it.
  logic unused_zero;
  assign unused_zero = Zero;

  alu_dec_112 u_alu_dec (
    .func      (func),
    .alu_ctr_c (dec_ctr),
    .illegal_c (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= S_IF;
    else     cur_state <= next_state;
  end

  // Retire count; terminal states always leave on the next edge, HALT never counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         instr_cnt <= '0;
    else if (is_terminal(cur_state)) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  always_comb begin
    next_state = cur_state;
    ctrl       = '0;
    case (cur_state)
      S_IF: begin
        ctrl.ir_wr     = 1'b1;
        ctrl.pc_wr     = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_ctr   = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        next_state     = S_ID;
      end
      S_ID: begin
        // Branch target is precomputed here so BR only has to compare.
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_ctr   = ALU_ADD;
        case (op)
          OP_RTYPE:        next_state = S_EX_R;
          OP_ORI, OP_ADDIU: next_state = S_EX_I;
          OP_LW, OP_SW:    next_state = S_MA;
          OP_BEQ:          next_state = S_BR;
          OP_J:            next_state = S_JMP;
`ifdef ILLEGAL_TRAP_EN
          default:         next_state = S_HALT;
`else
          default:         next_state = S_IF;
`endif
        endcase
      end
      S_EX_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_ctr   = dec_ctr;
`ifdef ILLEGAL_TRAP_EN
        next_state     = dec_illegal ? S_HALT : S_WB_R;
`else
        next_state     = S_WB_R;
`endif
      end
      S_WB_R: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = ~dec_illegal;
        next_state   = S_IF;
      end
      S_EX_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        if (op == OP_ORI) begin
          ctrl.ext_op  = 1'b0;
          ctrl.alu_ctr = ALU_OR;
        end else begin
          ctrl.ext_op  = 1'b1;
          ctrl.alu_ctr = ALU_ADD;
        end
        next_state = S_WB_I;
      end
      S_WB_I: begin
        ctrl.reg_wr = 1'b1;
        next_state  = S_IF;
      end
      S_MA: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_op    = 1'b1;
        ctrl.alu_ctr   = ALU_ADD;
        next_state     = (op == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        ctrl.iord  = 1'b1;
        next_state = S_MWB;
      end
      S_MWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_wr     = 1'b1;
        next_state      = S_IF;
      end
      S_MWR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_wr = 1'b1;
        next_state  = S_IF;
      end
      S_BR: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_ctr    = ALU_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.pc_wr_cond = 1'b1;
        next_state      = S_IF;
      end
      S_JMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        ctrl.pc_wr  = 1'b1;
        next_state  = S_IF;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: next_state = S_HALT;
`endif
      default: next_state = S_IF;
    endcase

    // Abandon any partial instruction without side effects while reset is held.
    if (rst) begin
      ctrl.pc_wr      = 1'b0;
      ctrl.pc_wr_cond = 1'b0;
      ctrl.ir_wr      = 1'b0;
      ctrl.reg_wr     = 1'b0;
      ctrl.mem_wr     = 1'b0;
    end
  end

  assign PCWr     = ctrl.pc_wr;
  assign PCWrCond = ctrl.pc_wr_cond;
  assign IorD     = ctrl.iord;
  assign MemWr    = ctrl.mem_wr;
  assign IRWr     = ctrl.ir_wr;
  assign RegDst   = ctrl.reg_dst;
  assign RegWr    = ctrl.reg_wr;
  assign MemtoReg = ctrl.mem_to_reg;
  assign ALUsrcA  = ctrl.alu_src_a;
  assign ALUsrcB  = ctrl.alu_src_b;
  assign ALUctr   = ctrl.alu_ctr;
  assign PCsrc    = ctrl.pc_src;
  assign ExtOp    = ctrl.ext_op;
  assign state    = cur_state;

endmodule

// File: tb/tb_multi_cycle_control_112.sv
// Bench for multi_cycle_control_112: vector table, random instruction stream and reset/trap sequences.
module tb_multi_cycle_control_112;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, func;
  logic        Zero;
  logic        PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, MemtoReg, ALUsrcA, ExtOp;
  logic [1:0]  ALUsrcB, PCsrc;
  logic [2:0]  ALUctr;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  logic [16:0] outs;
  assign outs = {PCWr, PCWrCond, IorD, MemWr, IRWr, RegDst, RegWr, MemtoReg,
                 ALUsrcA, ALUsrcB, ALUctr, PCsrc, ExtOp};

  // Bits of outs that are write enables: PCWr, PCWrCond, MemWr, IRWr, RegWr.
  localparam logic [16:0] EN_MASK = 17'h1B400;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] model_cnt = 0;

  multi_cycle_control_112 #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .Zero(Zero),
    .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD), .MemWr(MemWr), .IRWr(IRWr),
    .RegDst(RegDst), .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUsrcA(ALUsrcA),
    .ALUsrcB(ALUsrcB), .ALUctr(ALUctr), .PCsrc(PCsrc), .ExtOp(ExtOp),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100011: return 3'b001;
      6'b100100: return 3'b010;
      6'b100101: return 3'b011;
      6'b101010: return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic func_known(input logic [5:0] f);
    return f == 6'b100001 || f == 6'b100011 || f == 6'b100100 ||
           f == 6'b100101 || f == 6'b101010;
  endfunction

  // Expected control word for a state number, from the per-state output lists.
  function automatic logic [16:0] exp_out(input logic [3:0] st, input logic [5:0] o, input logic [5:0] f);
    logic pcwr, pccond, iord, memwr, irwr, regdst, regwr, m2r, srca, ext;
    logic [1:0] srcb, pcsrc;
    logic [2:0] ctr;
    {pcwr, pccond, iord, memwr, irwr, regdst, regwr, m2r, srca, ext} = '0;
    srcb = 2'b00; pcsrc = 2'b00; ctr = 3'b000;
    case (st)
      4'd0:  begin pcwr = 1; irwr = 1; srcb = 2'b01; end
      4'd1:  begin srcb = 2'b11; ext = 1; end
      4'd2:  begin srca = 1; ctr = alu_of(f); end
      4'd3:  begin regdst = 1; regwr = func_known(f); end
      4'd4:  begin srca = 1; srcb = 2'b10;
                   if (o == 6'b001101) ctr = 3'b011; else ext = 1; end
      4'd5:  regwr = 1;
      4'd6:  begin srca = 1; srcb = 2'b10; ext = 1; end
      4'd7:  iord = 1;
      4'd8:  begin m2r = 1; regwr = 1; end
      4'd9:  begin iord = 1; memwr = 1; end
      4'd10: begin srca = 1; ctr = 3'b001; pcsrc = 2'b01; pccond = 1; end
      4'd11: begin pcsrc = 2'b10; pcwr = 1; end
      default: ;
    endcase
    return {pcwr, pccond, iord, memwr, irwr, regdst, regwr, m2r, srca, srcb, ctr, pcsrc, ext};
  endfunction

  // Reference instruction path: state numbers packed as nibbles, first state in the low nibble.
  task automatic exp_path(input logic [5:0] o, output int len, output logic [19:0] seq, output bit counted);
    counted = 1'b1;
    case (o)
      6'b000000: begin len = 4; seq = 20'h03210; end
      6'b001101,
      6'b001001: begin len = 4; seq = 20'h05410; end
      6'b100011: begin len = 5; seq = 20'h87610; end
      6'b101011: begin len = 4; seq = 20'h09610; end
      6'b000100: begin len = 3; seq = 20'h00A10; end
      6'b000010: begin len = 3; seq = 20'h00B10; end
      default:   begin len = 2; seq = 20'h00010; counted = 1'b0; end
    endcase
  endtask

  // Called at a falling edge with the DUT in IF; returns at the falling edge of the next IF.
  task automatic run_seq(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                         input int len, input logic [19:0] seq, input bit counted);
    logic [3:0] es;
    op = o; func = f; Zero = z;
    #1;
    for (int k = 0; k < len; k++) begin
      es = seq[k*4 +: 4];
      check({name, " state"}, 32'(state), 32'(es));
      check({name, " outs"}, 32'(outs), 32'(exp_out(es, o, f)));
      @(posedge clk);
      @(negedge clk);
    end
    if (counted) model_cnt = model_cnt + 32'd1;
    check({name, " cnt"}, instr_cnt, model_cnt);
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    logic       zero;
    int         len;
    logic [19:0] seq;
    bit         counted;
  } vec_t;

  vec_t vt[$];

  initial begin
    int          len;
    logic [19:0] seq;
    bit          counted;
    logic [5:0]  ops[8];
    logic [5:0]  funcs[7];
    int          n_ops, n_funcs;

    ops   = '{6'h00, 6'h0D, 6'h09, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    funcs = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h3F};
`ifdef ILLEGAL_TRAP_EN
    n_ops = 7; n_funcs = 5;
`else
    n_ops = 8; n_funcs = 7;
`endif

    vt.push_back('{"subu",  6'h00, 6'h23, 1'b0, 4, 20'h03210, 1'b1});
    vt.push_back('{"addu",  6'h00, 6'h21, 1'b0, 4, 20'h03210, 1'b1});
    vt.push_back('{"and",   6'h00, 6'h24, 1'b1, 4, 20'h03210, 1'b1});
    vt.push_back('{"or",    6'h00, 6'h25, 1'b0, 4, 20'h03210, 1'b1});
    vt.push_back('{"slt",   6'h00, 6'h2A, 1'b0, 4, 20'h03210, 1'b1});
    vt.push_back('{"ori",   6'h0D, 6'h25, 1'b0, 4, 20'h05410, 1'b1});
    vt.push_back('{"addiu", 6'h09, 6'h00, 1'b0, 4, 20'h05410, 1'b1});
    vt.push_back('{"lw",    6'h23, 6'h00, 1'b0, 5, 20'h87610, 1'b1});
    vt.push_back('{"sw",    6'h2B, 6'h00, 1'b0, 4, 20'h09610, 1'b1});
    vt.push_back('{"beq_t", 6'h04, 6'h00, 1'b1, 3, 20'h00A10, 1'b1});
    vt.push_back('{"beq_n", 6'h04, 6'h00, 1'b0, 3, 20'h00A10, 1'b1});
    vt.push_back('{"j",     6'h02, 6'h00, 1'b0, 3, 20'h00B10, 1'b1});
`ifndef ILLEGAL_TRAP_EN
    vt.push_back('{"rbad",  6'h00, 6'h00, 1'b0, 4, 20'h03210, 1'b1});
    vt.push_back('{"opbad", 6'h3F, 6'h00, 1'b0, 2, 20'h00010, 1'b0});
`endif

    // Reset state: IF with every write enable suppressed.
    rst = 1'b1; op = 6'h00; func = 6'h00; Zero = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst state", 32'(state), 32'd0);
    check("rst cnt", instr_cnt, 32'd0);
    check("rst outs", 32'(outs), 32'(exp_out(4'd0, 6'h00, 6'h00) & ~EN_MASK));
    rst = 1'b0;

    foreach (vt[i])
      run_seq(vt[i].name, vt[i].op, vt[i].func, vt[i].zero, vt[i].len, vt[i].seq, vt[i].counted);

    for (int i = 0; i < 40; i++) begin
      logic [5:0] o, f;
      o = ops[$urandom_range(n_ops - 1)];
      f = (o == 6'h00) ? funcs[$urandom_range(n_funcs - 1)] : 6'($urandom);
      exp_path(o, len, seq, counted);
      run_seq($sformatf("rnd%0d op%0h f%0h", i, o, f), o, f, 1'($urandom), len, seq, counted);
    end

    // Asynchronous reset in the middle of a load's address phase.
    op = 6'h23; func = 6'h00;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("pre-rst MA state", 32'(state), 32'd6);
    rst = 1'b1;
    #1;
    check("async rst state", 32'(state), 32'd0);
    check("async rst cnt", instr_cnt, 32'd0);
    check("async rst outs", 32'(outs), 32'(exp_out(4'd0, 6'h23, 6'h00) & ~EN_MASK));
    @(posedge clk); #1;
    check("rst held outs", 32'(outs), 32'(exp_out(4'd0, 6'h23, 6'h00) & ~EN_MASK));
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    #1;
    check("post-rst state", 32'(state), 32'd0);
    check("post-rst IF outs", 32'(outs), 32'(exp_out(4'd0, 6'h23, 6'h00)));
    run_seq("post-rst addiu", 6'h09, 6'h00, 1'b0, 4, 20'h05410, 1'b1);

`ifdef ILLEGAL_TRAP_EN
    // Unknown op parks in HALT with no enables and a frozen counter until reset.
    op = 6'h3F; func = 6'h00;
    #1;
    check("trap IF", 32'(state), 32'd0);
    @(posedge clk); @(negedge clk);
    check("trap ID", 32'(state), 32'd1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      check("halt state", 32'(state), 32'd12);
      check("halt outs", 32'(outs), 32'd0);
      check("halt cnt", instr_cnt, model_cnt);
    end
    rst = 1'b1; #1;
    check("halt rst state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
    run_seq("after halt j", 6'h02, 6'h00, 1'b0, 3, 20'h00B10, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
